gshare_predictor: RTL and testbench
===================================

# gshare_predictor

Parametrised branch direction predictor: a table of 2^IDX_W saturating CTR_W-bit counters, indexed either by PC alone (bimodal) or by PC XOR a global history register (gshare). Lookup and resolve are split into separate ports with a one-cycle registered prediction path. Built-in hit/total statistics counters let the bench and system report accuracy without external bookkeeping. It is the next-generation replacement for the fixed 2-bit PC-indexed BHT in the front-end prediction path.

## Interface
- PC_W, 9, width of lookup PC
- IDX_W, 6, table index width; 2^IDX_W entries; PC_W >= IDX_W required
- CTR_W, 2, counter width; CTR_W >= 1
- HIST_W, 4, global history length; 1 <= HIST_W <= IDX_W required
- GSHARE, 1, 1 = index is PC XOR history; 0 = index is PC only, history still tracked
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- lookup_valid  in  1  lookup request this cycle
- lookup_pc  in  PC_W  branch PC to predict
- pred_valid  out  1  registered; high the cycle after an accepted lookup
- prediction  out  1  registered predicted direction (1 = taken)
- pred_idx  out  IDX_W  registered table index used; returned on update
- update_valid  in  1  branch resolved this cycle
- update_idx  in  IDX_W  index returned from pred_idx of that branch
- update_taken  in  1  actual outcome
- update_pred  in  1  prediction originally issued for that branch
- stat_total  out  32  number of updates since reset
- stat_correct  out  32  updates with update_pred == update_taken

## Operation
- Index: idx = lookup_pc[IDX_W-1:0] XOR {zero-extend ghr to IDX_W} when GSHARE=1; lookup_pc[IDX_W-1:0] when GSHARE=0.
- Prediction = MSB of counter at idx.
- Update at update_idx: taken -> counter+1 saturating at 2^CTR_W-1; not taken -> counter-1 saturating at 0.
- History on update_valid: ghr <= {ghr[HIST_W-2:0], update_taken} (HIST_W=1: ghr <= update_taken). History advances only on update, never speculatively on lookup.
- Stats on update_valid: stat_total +1; stat_correct +1 iff update_pred == update_taken. Both wrap modulo 2^32.
- Reset values: every counter = 2^(CTR_W-1)-1 (weakly not-taken; 0 when CTR_W=1), ghr = 0, pred_valid = 0, prediction = 0, pred_idx = 0, stat_total = 0, stat_correct = 0.

## Timing
- Lookup latency 1 cycle: lookup at edge k -> pred_valid/prediction/pred_idx valid after edge k.
- lookup_valid low: pred_valid drops to 0 next cycle; prediction and pred_idx hold last value.
- Update takes effect at the edge it is sampled; visible to lookups in the following cycle.
- Simultaneous lookup and update, same or different index: lookup uses pre-update counter and pre-update ghr (read-before-write, no bypass).
- Back-to-back lookups and updates every cycle are supported; no stall, no backpressure.
- Reset asserted mid-operation: all state returns to reset values immediately; any in-flight lookup is dropped (pred_valid 0), and updates sampled during reset are ignored.

## Structure
- Shared package bp_pkg: counter init-value function, saturating inc/dec functions, index-hash function (parametrised by widths).
- One sub-module: bp_pht (counter array, asynchronous reset, one read port, one write port, read-before-write). Top holds ghr, index hash, output registers, stats.

## Test plan
- After reset, lookup pc=0x005 (ghr=0) -> next cycle pred_valid=1, prediction=0, pred_idx=0x05; stat_total=0.
- GSHARE=0: two updates idx 0x05 taken -> counter 1->2->3, lookup 0x005 predicts 1; third taken holds 3; four not-taken -> 2,1,0,0, prediction 0.
- GSHARE=1: updates taken,taken,not-taken,taken -> ghr=4'b1101; lookup pc=0x1F0 -> pred_idx=0x3D.
- Same-cycle lookup pc=0x005 and taken update idx 0x05 with counter=1, GSHARE=0 -> prediction 0; next lookup -> prediction 1.
- 10 updates, 7 with update_pred==update_taken -> stat_total=10, stat_correct=7; then assert reset 1 cycle mid-traffic -> stats 0, ghr 0, all counters 1, pred_valid 0.
- lookup_valid deasserted for 3 cycles after a prediction of 1 -> pred_valid 0, prediction stays 1, pred_idx unchanged.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared helpers for the branch direction predictor.
//
// Purpose: width-generic arithmetic used by the pattern history table and
// the predictor top level. Functions operate on 32-bit containers so that a
// single definition serves every CTR_W / IDX_W choice; callers size-cast the
// result back to the width they need.
//
// Contents:
//   ctr_init     - reset value of a counter (weakly not-taken)
//   ctr_sat_inc  - saturating increment at 2^ctr_w - 1
//   ctr_sat_dec  - saturating decrement at 0
//   bp_hash_idx  - table index from PC low bits, optionally XOR history
package bp_pkg;

    // Weakly not-taken: the value just below the taken/not-taken midpoint.
    // A 1-bit counter has no "weak" state, so it starts at plain not-taken.
    function automatic logic [31:0] ctr_init(input int ctr_w);
        if (ctr_w <= 1) begin
            return 32'd0;
        end
        return (32'd1 << (ctr_w - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] ctr_sat_inc(input logic [31:0] value,
                                                input int          ctr_w);
        logic [32:0] max_val;
        max_val = (33'd1 << ctr_w) - 33'd1;
        if ({1'b0, value} >= max_val) begin
            return value;
        end
        return value + 32'd1;
    endfunction

    function automatic logic [31:0] ctr_sat_dec(input logic [31:0] value);
        if (value == 32'd0) begin
            return 32'd0;
        end
        return value - 32'd1;
    endfunction

    // History is already zero-extended by the caller, so a short history
    // only perturbs the low index bits.
    function automatic logic [31:0] bp_hash_idx(input logic [31:0] pc,
                                                input logic [31:0] hist,
                                                input logic        gshare,
                                                input int          idx_w);
        logic [32:0] mask;
        logic [31:0] raw;
        mask = (33'd1 << idx_w) - 33'd1;
        raw  = gshare ? (pc ^ hist) : pc;
        return raw & mask[31:0];
    endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: 2^IDX_W saturating CTR_W-bit counters.
//
// Ports:
//   clk, reset  - clock, asynchronous active-high reset (all counters to init)
//   rd_idx      - read index (combinational read)
//   rd_pred     - MSB of the counter at rd_idx (1 = predict taken)
//   wr_en       - train the counter at wr_idx this cycle
//   wr_idx      - index being trained
//   wr_taken    - resolved outcome; counts up when taken, down otherwise
//
// The read is combinational from the stored array, so a read and a write to
// the same entry in one cycle return the pre-update value.
module bp_pht
    import bp_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int CTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_pred,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam logic [CTR_W-1:0] INIT_VAL = CTR_W'(ctr_init(CTR_W));

    logic [CTR_W-1:0] ctr_mem [ENTRIES];
    logic [CTR_W-1:0] cur_ctr;
    logic [CTR_W-1:0] next_ctr;
    logic [31:0]      next_ext;

    assign rd_pred = ctr_mem[rd_idx][CTR_W-1];

    // Read-modify-write value for the entry being trained.
    always_comb begin
        cur_ctr  = ctr_mem[wr_idx];
        next_ext = wr_taken ? ctr_sat_inc(32'(cur_ctr), CTR_W)
                            : ctr_sat_dec(32'(cur_ctr));
        next_ctr = CTR_W'(next_ext);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_mem[i] <= INIT_VAL;
            end
        end else if (wr_en) begin
            ctr_mem[wr_idx] <= next_ctr;
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// Branch direction predictor, bimodal or gshare indexed.
//
// Parameters:
//   PC_W   - lookup PC width (<= 32, >= IDX_W)
//   IDX_W  - table index width, 2^IDX_W counters
//   CTR_W  - counter width (>= 1)
//   HIST_W - global history length (1 .. IDX_W)
//   GSHARE - 1: index = PC XOR history; 0: index = PC (history still kept)
//
// Ports:
//   clk, reset                - clock, asynchronous active-high reset
//   lookup_valid, lookup_pc   - prediction request
//   pred_valid                - registered; high the cycle after a lookup
//   prediction, pred_idx      - registered direction and table index used;
//                               both hold while no lookup is issued
//   update_valid, update_idx  - resolved branch and the index it predicted with
//   update_taken, update_pred - actual outcome and the prediction issued
//   stat_total, stat_correct  - resolved branches / correctly predicted ones
//
// History advances only on resolution, never on lookup, so the index a
// branch is trained at is exactly the pred_idx it was given.
module gshare_predictor
    import bp_pkg::*;
#(
    parameter int PC_W   = 9,
    parameter int IDX_W  = 6,
    parameter int CTR_W  = 2,
    parameter int HIST_W = 4,
    parameter int GSHARE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lookup_valid,
    input  logic [PC_W-1:0]   lookup_pc,
    output logic              pred_valid,
    output logic              prediction,
    output logic [IDX_W-1:0]  pred_idx,
    input  logic              update_valid,
    input  logic [IDX_W-1:0]  update_idx,
    input  logic              update_taken,
    input  logic              update_pred,
    output logic [31:0]       stat_total,
    output logic [31:0]       stat_correct
);

    localparam logic USE_GSHARE = (GSHARE != 0);

    logic [HIST_W-1:0] ghr;
    logic [IDX_W-1:0]  lookup_idx;
    logic              table_pred;

    // The lookup sees the current (pre-update) history; any update in the
    // same cycle only shifts ghr at the edge.
    assign lookup_idx = IDX_W'(bp_hash_idx(32'(lookup_pc), 32'(ghr),
                                           USE_GSHARE, IDX_W));

    bp_pht #(
        .IDX_W (IDX_W),
        .CTR_W (CTR_W)
    ) u_pht (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (lookup_idx),
        .rd_pred  (table_pred),
        .wr_en    (update_valid),
        .wr_idx   (update_idx),
        .wr_taken (update_taken)
    );

    // Global history: newest outcome enters at bit 0, oldest falls off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ghr <= '0;
        end else if (update_valid) begin
            ghr <= HIST_W'({ghr, update_taken});
        end
    end

    // Registered prediction path; direction and index hold when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pred_valid <= 1'b0;
            prediction <= 1'b0;
            pred_idx   <= '0;
        end else begin
            pred_valid <= lookup_valid;
            if (lookup_valid) begin
                prediction <= table_pred;
                pred_idx   <= lookup_idx;
            end
        end
    end

    // Accuracy statistics, wrapping modulo 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_total   <= '0;
            stat_correct <= '0;
        end else if (update_valid) begin
            stat_total <= stat_total + 32'd1;
            if (update_pred == update_taken) begin
                stat_correct <= stat_correct + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed testbench for gshare_predictor. Two instances share the same
// stimulus: u_bim (GSHARE=0) and u_gsh (GSHARE=1).
module tb_gshare_predictor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       lookup_valid = 1'b0;
    logic [8:0] lookup_pc = '0;
    logic       update_valid = 1'b0;
    logic [5:0] update_idx = '0;
    logic       update_taken = 1'b0;
    logic       update_pred = 1'b0;

    logic        bim_pred_valid, bim_prediction;
    logic [5:0]  bim_pred_idx;
    logic [31:0] bim_stat_total, bim_stat_correct;
    logic        gsh_pred_valid, gsh_prediction;
    logic [5:0]  gsh_pred_idx;
    logic [31:0] gsh_stat_total, gsh_stat_correct;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gshare_predictor #(.PC_W(9), .IDX_W(6), .CTR_W(2), .HIST_W(4), .GSHARE(0)) u_bim (
        .clk(clk), .reset(reset),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .pred_valid(bim_pred_valid), .prediction(bim_prediction), .pred_idx(bim_pred_idx),
        .update_valid(update_valid), .update_idx(update_idx),
        .update_taken(update_taken), .update_pred(update_pred),
        .stat_total(bim_stat_total), .stat_correct(bim_stat_correct)
    );

    gshare_predictor #(.PC_W(9), .IDX_W(6), .CTR_W(2), .HIST_W(4), .GSHARE(1)) u_gsh (
        .clk(clk), .reset(reset),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .pred_valid(gsh_pred_valid), .prediction(gsh_prediction), .pred_idx(gsh_pred_idx),
        .update_valid(update_valid), .update_idx(update_idx),
        .update_taken(update_taken), .update_pred(update_pred),
        .stat_total(gsh_stat_total), .stat_correct(gsh_stat_correct)
    );

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        lookup_valid = 1'b0;
        update_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic do_lookup(input logic [8:0] pc);
        lookup_valid = 1'b1;
        lookup_pc    = pc;
        step();
        lookup_valid = 1'b0;
    endtask

    task automatic do_update(input logic [5:0] idx, input logic taken, input logic pred);
        update_valid = 1'b1;
        update_idx   = idx;
        update_taken = taken;
        update_pred  = pred;
        step();
        update_valid = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (bim_pred_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_pred_valid: got %0b expected 0", bim_pred_valid);
        end
        checks++;
        if (bim_pred_idx !== 6'h00 || bim_prediction !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_outputs: got idx %0h pred %0b expected idx 0 pred 0", bim_pred_idx, bim_prediction);
        end
        checks++;
        if (gsh_stat_total !== 32'd0 || gsh_stat_correct !== 32'd0) begin
            failures++; $display("[TB] FAIL reset_stats: got %0d/%0d expected 0/0", gsh_stat_total, gsh_stat_correct);
        end
        do_lookup(9'h005);
        checks++;
        if (bim_pred_valid !== 1'b1 || bim_prediction !== 1'b0 || bim_pred_idx !== 6'h05) begin
            failures++; $display("[TB] FAIL first_lookup_bim: got v%0b p%0b idx %0h expected v1 p0 idx 05", bim_pred_valid, bim_prediction, bim_pred_idx);
        end
        checks++;
        if (gsh_pred_valid !== 1'b1 || gsh_prediction !== 1'b0 || gsh_pred_idx !== 6'h05) begin
            failures++; $display("[TB] FAIL first_lookup_gsh: got v%0b p%0b idx %0h expected v1 p0 idx 05", gsh_pred_valid, gsh_prediction, gsh_pred_idx);
        end
        checks++;
        if (bim_stat_total !== 32'd0) begin
            failures++; $display("[TB] FAIL first_lookup_stats: got %0d expected 0", bim_stat_total);
        end
    endtask

    // Counter at idx 5 starts at 1. Each row: outcome applied, then the
    // prediction expected from a lookup of pc 0x005.
    task automatic test_saturation();
        logic [1:0] seq_taken [11];
        logic       seq_exp   [11];
        // counter: 1 ->2 ->3 ->3 ->2 ->1 ->0 ->0 ->1 ->2 ->1
        seq_taken = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0};
        seq_exp   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        seq_exp[10] = 1'b0; // 1 -> 0 after final not-taken
        for (int i = 0; i < 11; i++) begin
            do_update(6'h05, seq_taken[i][0], 1'b0);
            do_lookup(9'h005);
            checks++;
            if (bim_prediction !== seq_exp[i]) begin
                failures++; $display("[TB] FAIL saturation_step%0d: got %0b expected %0b", i, bim_prediction, seq_exp[i]);
            end
        end
    endtask

    task automatic test_gshare_index();
        do_reset();
        do_update(6'h10, 1'b1, 1'b0);
        do_update(6'h10, 1'b1, 1'b0);
        do_update(6'h10, 1'b0, 1'b0);
        do_update(6'h10, 1'b1, 1'b0);
        do_lookup(9'h1F0);
        checks++;
        if (gsh_pred_idx !== 6'h3D || gsh_prediction !== 1'b0) begin
            failures++; $display("[TB] FAIL gshare_idx_1101: got idx %0h p%0b expected idx 3d p0", gsh_pred_idx, gsh_prediction);
        end
        checks++;
        if (bim_pred_idx !== 6'h30) begin
            failures++; $display("[TB] FAIL bimodal_idx_ignores_ghr: got %0h expected 30", bim_pred_idx);
        end
        // ghr 1101 -> 1011: oldest bit must fall off
        do_update(6'h10, 1'b1, 1'b0);
        do_lookup(9'h1F0);
        checks++;
        if (gsh_pred_idx !== 6'h3B) begin
            failures++; $display("[TB] FAIL gshare_idx_1011: got %0h expected 3b", gsh_pred_idx);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        lookup_valid = 1'b1; lookup_pc = 9'h005;
        update_valid = 1'b1; update_idx = 6'h05; update_taken = 1'b1; update_pred = 1'b0;
        step();
        lookup_valid = 1'b0; update_valid = 1'b0;
        checks++;
        if (bim_prediction !== 1'b0) begin
            failures++; $display("[TB] FAIL same_cycle_read_old: got %0b expected 0", bim_prediction);
        end
        checks++;
        if (gsh_pred_idx !== 6'h05) begin
            failures++; $display("[TB] FAIL same_cycle_old_ghr: got %0h expected 05", gsh_pred_idx);
        end
        do_lookup(9'h005);
        checks++;
        if (bim_prediction !== 1'b1) begin
            failures++; $display("[TB] FAIL same_cycle_then_new: got %0b expected 1", bim_prediction);
        end
        checks++;
        if (gsh_pred_idx !== 6'h04) begin
            failures++; $display("[TB] FAIL same_cycle_ghr_after: got %0h expected 04", gsh_pred_idx);
        end
    endtask

    task automatic test_stats_and_reset();
        logic st_taken [10];
        logic st_pred  [10];
        do_reset();
        // correct: 1,0,1,1,1,0,1,1,0,1 -> 7 of 10; counter at 5 ends at 3
        st_taken = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        st_pred  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            do_update(6'h05, st_taken[i], st_pred[i]);
        end
        checks++;
        if (bim_stat_total !== 32'd10 || bim_stat_correct !== 32'd7) begin
            failures++; $display("[TB] FAIL stats_10_7: got %0d/%0d expected 10/7", bim_stat_total, bim_stat_correct);
        end
        // Traffic cycle, then reset asserted away from the clock edge.
        lookup_valid = 1'b1; lookup_pc = 9'h005;
        update_valid = 1'b1; update_idx = 6'h05; update_taken = 1'b1; update_pred = 1'b1;
        step();
        checks++;
        if (bim_pred_valid !== 1'b1 || bim_prediction !== 1'b1 || bim_stat_total !== 32'd11) begin
            failures++; $display("[TB] FAIL pre_reset_traffic: got v%0b p%0b total %0d expected v1 p1 total 11", bim_pred_valid, bim_prediction, bim_stat_total);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bim_stat_total !== 32'd0 || bim_stat_correct !== 32'd0 || bim_pred_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL async_reset: got total %0d correct %0d v%0b expected 0 0 v0", bim_stat_total, bim_stat_correct, bim_pred_valid);
        end
        step();
        reset = 1'b0;
        lookup_valid = 1'b0; update_valid = 1'b0;
        #2;
        checks++;
        if (bim_stat_total !== 32'd0 || bim_pred_valid !== 1'b0 || gsh_stat_total !== 32'd0) begin
            failures++; $display("[TB] FAIL reset_drops_traffic: got total %0d v%0b expected 0 v0", bim_stat_total, bim_pred_valid);
        end
        do_lookup(9'h005);
        checks++;
        if (bim_prediction !== 1'b0 || gsh_pred_idx !== 6'h05) begin
            failures++; $display("[TB] FAIL post_reset_state: got p%0b gidx %0h expected p0 gidx 05", bim_prediction, gsh_pred_idx);
        end
        // One taken from init value 1 must reach 2 (predict taken).
        do_update(6'h05, 1'b1, 1'b0);
        do_lookup(9'h005);
        checks++;
        if (bim_prediction !== 1'b1) begin
            failures++; $display("[TB] FAIL post_reset_init_one: got %0b expected 1", bim_prediction);
        end
    endtask

    task automatic test_hold();
        // Counter at idx 5 is 2 from the previous scenario.
        do_lookup(9'h005);
        lookup_pc = 9'h02A;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bim_pred_valid !== 1'b0 || bim_prediction !== 1'b1 || bim_pred_idx !== 6'h05) begin
                failures++; $display("[TB] FAIL hold_cycle%0d: got v%0b p%0b idx %0h expected v0 p1 idx 05", i, bim_pred_valid, bim_prediction, bim_pred_idx);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] pcs      [3];
        logic       exp_pred [3];
        logic [5:0] exp_gidx [3];
        do_reset();
        do_update(6'h03, 1'b1, 1'b0);
        do_update(6'h03, 1'b1, 1'b0);
        // ghr = 0011 now; gshare indices are pc ^ 3
        pcs      = '{9'h003, 9'h004, 9'h003};
        exp_pred = '{1'b1, 1'b0, 1'b1};
        exp_gidx = '{6'h00, 6'h07, 6'h00};
        lookup_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lookup_pc = pcs[i];
            step();
            checks++;
            if (bim_pred_valid !== 1'b1 || bim_prediction !== exp_pred[i] || bim_pred_idx !== pcs[i][5:0]) begin
                failures++; $display("[TB] FAIL b2b_bim%0d: got v%0b p%0b idx %0h expected v1 p%0b idx %0h", i, bim_pred_valid, bim_prediction, bim_pred_idx, exp_pred[i], pcs[i][5:0]);
            end
            checks++;
            if (gsh_pred_idx !== exp_gidx[i]) begin
                failures++; $display("[TB] FAIL b2b_gsh%0d: got %0h expected %0h", i, gsh_pred_idx, exp_gidx[i]);
            end
        end
        lookup_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        test_reset();
        test_saturation();
        test_gshare_index();
        test_same_cycle();
        test_stats_and_reset();
        test_hold();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
